// File: rtl/mdio_pkg.sv
// Shared definitions for the MDIO station-management controller and peripheral:
// opcodes, Clause-22 field positions, frame lengths and FSM state encodings.
package mdio_pkg;

   localparam logic [1:0] OP_WRITE = 2'b01;
   localparam logic [1:0] OP_READ  = 2'b10;

   localparam int ST_MSB   = 31;
   localparam int OP_MSB   = 29;
   localparam int PHY_MSB  = 27;
   localparam int REG_MSB  = 22;
   localparam int TA_MSB   = 17;
   localparam int DATA_MSB = 15;

   localparam int FRAME_BITS = 32;
   localparam int HDR_BITS   = 16;

   localparam logic [5:0] FRAME_LAST = 6'(FRAME_BITS - 1);
   localparam logic [5:0] HDR_LAST   = 6'(HDR_BITS - 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_DRIVE  = 2'd1,
      S_SAMPLE = 2'd2,
      S_DONE   = 2'd3
   } state_t;

   function automatic logic op_is_read(input logic [1:0] op);
      return (op == OP_READ);
   endfunction

endpackage

// File: rtl/mdc_gen.sv
// MDC bit-timing generator: each bit is CLK_DIV cycles low then CLK_DIV cycles high,
// with single-cycle enables marking the rising edge and the last cycle of the bit.
module mdc_gen #(
   parameter int unsigned CLK_DIV = 2
) (
   input  logic CLK,
   input  logic RESET,
   input  logic run,
   output logic MDC,
   output logic mdc_rise,
   output logic bit_end
);

   localparam logic [7:0] HALF_LAST = 8'(CLK_DIV - 1);

   logic [7:0] half_q, half_d;
   logic       phase_q, phase_d;
   logic       mdc_q, mdc_d;

   // Half-period counter and phase; MDC is the phase delayed to line up with the data outputs.
   always_comb begin
      half_d  = half_q;
      phase_d = phase_q;
      mdc_d   = 1'b0;
      if (!run) begin
         half_d  = 8'd0;
         phase_d = 1'b0;
      end else begin
         mdc_d = phase_q;
         if (half_q == HALF_LAST) begin
            half_d  = 8'd0;
            phase_d = ~phase_q;
         end else begin
            half_d = half_q + 8'd1;
         end
      end
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         half_q  <= 8'd0;
         phase_q <= 1'b0;
         mdc_q   <= 1'b0;
      end else begin
         half_q  <= half_d;
         phase_q <= phase_d;
         mdc_q   <= mdc_d;
      end
   end

   assign MDC      = mdc_q;
   assign mdc_rise = run & phase_q & (half_q == 8'd0);
   assign bit_end  = run & phase_q & (half_q == HALF_LAST);

endmodule

// File: rtl/mdio_controller.sv
// MDIO master: serializes a Clause-22 frame MSB-first, releases the line after
// turnaround on reads and captures 16 data bits. All outputs are registered.
module mdio_controller
   import mdio_pkg::*;
#(
   parameter int unsigned CLK_DIV = 2
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        MDIO_START,
   input  logic [31:0] T_DATA,
   input  logic        MDIO_IN,
   output logic        MDC,
   output logic        MDIO_OUT,
   output logic        MDIO_OE,
   output logic [15:0] RD_DATA,
   output logic        DATA_RDY,
   output logic        MDIO_DONE,
   output logic        BUSY
);

   state_t      state_q, state_d;
   logic [31:0] shift_q, shift_d;
   logic [5:0]  bit_cnt_q, bit_cnt_d;
   logic [15:0] rd_shift_q, rd_shift_d;
   logic        is_read_q, is_read_d;
   logic        mdio_out_q, mdio_out_d;
   logic        mdio_oe_q, mdio_oe_d;
   logic [15:0] rd_data_q, rd_data_d;
   logic        data_rdy_q, data_rdy_d;
   logic        done_q, done_d;
   logic        busy_q, busy_d;
   logic        run_s, mdc_rise_s, bit_end_s;

   assign run_s = (state_q == S_DRIVE) || (state_q == S_SAMPLE);

   mdc_gen #(.CLK_DIV(CLK_DIV)) u_mdc_gen (
      .CLK      (CLK),
      .RESET    (RESET),
      .run      (run_s),
      .MDC      (MDC),
      .mdc_rise (mdc_rise_s),
      .bit_end  (bit_end_s)
   );

   // Next-state and next-output logic; outputs reflect the state one cycle later.
   always_comb begin
      state_d    = state_q;
      shift_d    = shift_q;
      bit_cnt_d  = bit_cnt_q;
      rd_shift_d = rd_shift_q;
      is_read_d  = is_read_q;
      rd_data_d  = rd_data_q;
      mdio_out_d = 1'b0;
      mdio_oe_d  = 1'b0;
      data_rdy_d = 1'b0;
      done_d     = 1'b0;
      busy_d     = 1'b1;
      case (state_q)
         S_IDLE: begin
            if (MDIO_START) begin
               shift_d    = T_DATA;
               bit_cnt_d  = 6'd0;
               rd_shift_d = 16'd0;
               is_read_d  = op_is_read(T_DATA[OP_MSB -: 2]);
               state_d    = S_DRIVE;
            end else begin
               busy_d = 1'b0;
            end
         end
         S_DRIVE: begin
            mdio_oe_d  = 1'b1;
            mdio_out_d = shift_q[31];
            if (bit_end_s) begin
               shift_d   = {shift_q[30:0], 1'b0};
               bit_cnt_d = bit_cnt_q + 6'd1;
               if (is_read_q && (bit_cnt_q == HDR_LAST)) begin
                  state_d = S_SAMPLE;
               end else if (bit_cnt_q == FRAME_LAST) begin
                  state_d = S_DONE;
               end else begin
                  state_d = S_DRIVE;
               end
            end else begin
               state_d = S_DRIVE;
            end
         end
         S_SAMPLE: begin
            if (mdc_rise_s) begin
               rd_shift_d = {rd_shift_q[14:0], MDIO_IN};
            end else begin
               rd_shift_d = rd_shift_q;
            end
            if (bit_end_s) begin
               bit_cnt_d = bit_cnt_q + 6'd1;
               state_d   = (bit_cnt_q == FRAME_LAST) ? S_DONE : S_SAMPLE;
            end else begin
               state_d = S_SAMPLE;
            end
         end
         S_DONE: begin
            done_d  = 1'b1;
            state_d = S_IDLE;
            if (is_read_q) begin
               rd_data_d  = rd_shift_q;
               data_rdy_d = 1'b1;
            end else begin
               data_rdy_d = 1'b0;
            end
         end
         default: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   // State, datapath and registered outputs.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state_q    <= S_IDLE;
         shift_q    <= 32'd0;
         bit_cnt_q  <= 6'd0;
         rd_shift_q <= 16'd0;
         is_read_q  <= 1'b0;
         mdio_out_q <= 1'b0;
         mdio_oe_q  <= 1'b0;
         rd_data_q  <= 16'd0;
         data_rdy_q <= 1'b0;
         done_q     <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         shift_q    <= shift_d;
         bit_cnt_q  <= bit_cnt_d;
         rd_shift_q <= rd_shift_d;
         is_read_q  <= is_read_d;
         mdio_out_q <= mdio_out_d;
         mdio_oe_q  <= mdio_oe_d;
         rd_data_q  <= rd_data_d;
         data_rdy_q <= data_rdy_d;
         done_q     <= done_d;
         busy_q     <= busy_d;
      end
   end

   assign MDIO_OUT  = mdio_out_q;
   assign MDIO_OE   = mdio_oe_q;
   assign RD_DATA   = rd_data_q;
   assign DATA_RDY  = data_rdy_q;
   assign MDIO_DONE = done_q;
   assign BUSY      = busy_q;

endmodule
